// File: rtl/uart_tx_if.sv
// Byte-request/status bundle between a byte producer and the UART transmitter.
// The producer drives the master side; the transmitter implements the slave side.
interface uart_tx_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output data_in,
        output data_valid,
        input  tx_ready,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output tx_ready,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register, so consecutive bytes
// stream with no idle gap between the stop bit and the next start bit.
module uart_tx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus_if
);
    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam logic [15:0] CNT_LAST     = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic [15:0] clk_count_q, clk_count_d;
    logic [2:0]  bit_index_q, bit_index_d;
    logic [7:0]  shift_q,     shift_d;
    logic [7:0]  hold_q,      hold_d;
    logic        hold_full_q, hold_full_d;
    logic        tx_q,        tx_d;
    logic        done_q,      done_d;

    logic        cnt_end;
    logic [2:0]  bit_index_inc;

    assign cnt_end       = (clk_count_q == CNT_LAST);
    assign bit_index_inc = bit_index_q + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            clk_count_q <= '0;
            bit_index_q <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_count_q <= clk_count_d;
            bit_index_q <= bit_index_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q;
        bit_index_d = bit_index_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;
        done_d      = 1'b0;

        // Accept needs an empty holder and drain needs a full one, so they never collide.
        if (bus_if.data_valid && !hold_full_q) begin
            hold_d      = bus_if.data_in;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    tx_d        = 1'b0;
                    clk_count_d = '0;
                    state_d     = START;
                end
            end
            START: begin
                if (cnt_end) begin
                    tx_d        = shift_q[0];
                    bit_index_d = '0;
                    clk_count_d = '0;
                    state_d     = DATA;
                end else begin
                    clk_count_d = clk_count_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_end) begin
                    clk_count_d = '0;
                    if (bit_index_q != 3'd7) begin
                        bit_index_d = bit_index_inc;
                        tx_d        = shift_q[bit_index_inc];
                    end else begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end
                end else begin
                    clk_count_d = clk_count_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_end) begin
                    done_d      = 1'b1;
                    clk_count_d = '0;
                    // A queued byte starts its start bit right after this stop bit.
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        tx_d        = 1'b0;
                        state_d     = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    clk_count_d = clk_count_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus_if.tx_ready = !hold_full_q;
    assign bus_if.tx       = tx_q;
    assign bus_if.busy     = (state_q != IDLE) || hold_full_q;
    assign bus_if.done     = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=10: reset, single frame,
// back-to-back streaming with an ignored overflow write, and mid-frame reset.
module tb_uart_tx;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    uart_tx_if bus ();

    uart_tx #(
        .CLK_FREQ  (100),
        .BAUD_RATE (10)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte for one edge (E0), then step to E1 where the start bit begins.
    task automatic send(input string tag, input logic [7:0] b);
        bus.data_in    = b;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        check({tag, "_e0_ready"}, 32'(bus.tx_ready), 32'd0);
        check({tag, "_e0_busy"},  32'(bus.busy),     32'd1);
        check({tag, "_e0_tx"},    32'(bus.tx),       32'd1);
        tick();
        check({tag, "_e1_tx"},    32'(bus.tx),       32'd0);
        check({tag, "_e1_ready"}, 32'(bus.tx_ready), 32'd1);
    endtask

    // Walk 100 cycles starting at the first start-bit cycle; optionally queue a
    // byte at cycle qa and attempt an overflow write at cycle ov.
    task automatic frame(input string tag, input logic [7:0] b,
                         input int qa, input logic [7:0] qb,
                         input int ov, input logic [7:0] ovb);
        logic [9:0] fr;
        int bad;
        int dn;
        fr  = {1'b1, b, 1'b0};
        bad = 0;
        dn  = 0;
        for (int i = 0; i < 100; i++) begin
            bus.data_valid = (i == qa) || (i == ov);
            if (i == qa) bus.data_in = qb;
            else if (i == ov) bus.data_in = ovb;
            if (i == ov) check({tag, "_ovf_ready"}, 32'(bus.tx_ready), 32'd0);
            if (bus.tx !== fr[i / 10]) bad++;
            if (i > 0 && bus.done) dn++;
            if (i % 10 == 5)
                check($sformatf("%s_cell%0d", tag, i / 10), 32'(bus.tx), 32'(fr[i / 10]));
            tick();
        end
        bus.data_valid = 1'b0;
        check({tag, "_bad_cycles"}, 32'(bad), 32'd0);
        check({tag, "_early_done"}, 32'(dn),  32'd0);
    endtask

    initial begin
        int cnt;
        int dn;
        n_cmp          = 0;
        n_err          = 0;
        rst            = 1'b1;
        bus.data_in    = 8'h00;
        bus.data_valid = 1'b0;

        // Reset and idle line
        tick(); tick(); tick();
        rst = 1'b0;
        check("rst_tx",    32'(bus.tx),       32'd1);
        check("rst_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_busy",  32'(bus.busy),     32'd0);
        check("rst_done",  32'(bus.done),     32'd0);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.tx !== 1'b1 || bus.done !== 1'b0) cnt++;
        end
        check("idle_200", 32'(cnt), 32'd0);

        // Single byte 0xA5
        send("a5", 8'hA5);
        frame("a5", 8'hA5, -1, 8'h00, -1, 8'h00);
        check("a5_done",  32'(bus.done),     32'd1);
        check("a5_busy",  32'(bus.busy),     32'd0);
        check("a5_tx",    32'(bus.tx),       32'd1);
        check("a5_ready", 32'(bus.tx_ready), 32'd1);
        tick();
        check("a5_done_clr", 32'(bus.done), 32'd0);
        for (int i = 0; i < 5; i++) tick();

        // Back-to-back 0x55 then 0x0F, with a 0xFF overflow write while full
        send("b1", 8'h55);
        frame("b1", 8'h55, 30, 8'h0F, 50, 8'hFF);
        check("b1_done", 32'(bus.done), 32'd1);
        check("b1_busy", 32'(bus.busy), 32'd1);
        check("b1_tx",   32'(bus.tx),   32'd0);
        frame("b2", 8'h0F, -1, 8'h00, -1, 8'h00);
        check("b2_done", 32'(bus.done), 32'd1);
        check("b2_busy", 32'(bus.busy), 32'd0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.tx !== 1'b1) cnt++;
        end
        check("ovf_no_frame", 32'(cnt), 32'd0);

        // Reset at cycle 35 of a 0x00 frame
        send("r0", 8'h00);
        for (int i = 0; i < 35; i++) tick();
        check("r0_mid_tx", 32'(bus.tx), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("r0_tx",    32'(bus.tx),       32'd1);
        check("r0_busy",  32'(bus.busy),     32'd0);
        check("r0_ready", 32'(bus.tx_ready), 32'd1);
        cnt = 0;
        dn  = 0;
        for (int i = 0; i < 120; i++) begin
            if (bus.tx !== 1'b1) cnt++;
            if (bus.done) dn++;
            tick();
        end
        check("r0_idle",    32'(cnt), 32'd0);
        check("r0_no_done", 32'(dn),  32'd0);

        // Clean frame after reset
        send("81", 8'h81);
        frame("81", 8'h81, -1, 8'h00, -1, 8'h00);
        check("81_done", 32'(bus.done), 32'd1);
        check("81_busy", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, 8N1 framing: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. Pairs with the team's UART receiver and sends ALU results back to the host. Has a one-byte holding register so the producer can queue the next byte during a frame. Back-to-back bytes go out with no idle gap.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer divide), required range 2..65535

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
data_in  input  8  byte to transmit
data_valid  input  1  request; byte accepted on a clock edge where data_valid && tx_ready
tx_ready  output  1  holding register empty; combinational from registered hold_full (= !hold_full)
tx  output  1  serial line, registered, idle high
busy  output  1  FSM not IDLE or holding register full
done  output  1  registered one-cycle pulse when a stop bit completes

Behaviour:
- Reset (rst high at a clk edge, any state, including mid-frame): state=IDLE, tx=1, done=0, hold_full=0, clk_count=0, bit_index=0, shift=0. Any partly sent or queued byte is dropped. After reset: tx_ready=1, busy=0.
- Holding register:
  - Loads data_in and sets hold_full on an edge with data_valid && !hold_full.
  - While hold_full=1, data_valid is ignored; the byte is not latched.
  - hold_full clears on the edge where the FSM moves the byte into the shift register.
  - tx_ready comes from registered hold_full only, so an accept and a drain never share an edge.
- FSM states: IDLE, START, DATA, STOP. clk_count is 16 bits; bit_index is 3 bits.
- IDLE:
  - tx=1.
  - If hold_full: shift<=hold, hold_full<=0, tx<=0, clk_count<=0, go to START.
- START:
  - Hold tx=0 for exactly CLKS_PER_BIT cycles; count up to CLKS_PER_BIT-1.
  - Then tx<=shift[0], bit_index<=0, clk_count<=0, go to DATA.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles.
  - At count end with bit_index<7: bit_index++, tx<=shift[bit_index+1].
  - At count end with bit_index==7: tx<=1, go to STOP.
- STOP:
  - Hold tx=1 for CLKS_PER_BIT cycles.
  - At count end: done<=1.
  - If hold_full: load shift from hold, clear hold_full, tx<=0, go to START. This gives a zero-gap back-to-back frame.
  - Otherwise go to IDLE.
- done is high for exactly one cycle and is cleared on every other edge.
- Latency:
  - Accept edge E0: hold loads.
  - E1: tx falls, if the FSM was IDLE.
  - Frame length: exactly 10*CLKS_PER_BIT cycles from tx fall to the end of the stop bit.
  - done is visible in the cycle after the stop bit ends, coinciding with the first cycle of IDLE or the next START.
- Throughput: continuous streaming gives one byte per 10*CLKS_PER_BIT cycles. The producer may queue the next byte any time during the current frame.
- busy: high from the edge after acceptance until the FSM returns to IDLE with the holding register empty.
- data_in is sampled only at acceptance; later changes have no effect.

Test Plan:
All tests use CLK_FREQ=100, BAUD_RATE=10 (CLKS_PER_BIT=10) unless stated.
1. Reset: hold rst 3 cycles, then release -> tx=1, tx_ready=1, busy=0, done=0; tx stays high for 200 idle cycles with data_valid=0.
2. Single byte 0xA5 accepted at E0 -> tx falls at E1, then 10-cycle cells read 0,1,0,1,0,0,1,0,1,1 (start, b0..b7, stop). done pulses exactly once, 100 cycles after E1. busy drops the same cycle and tx_ready stays 1 after the load.
3. Back-to-back: send 0x55, then 0x0F during frame 1 -> second start bit begins the cycle right after the first stop bit. Total 200 cycles, no idle gap, two done pulses 100 cycles apart.
4. Overflow: while 0x55 is in flight and 0x0F is queued (tx_ready=0), pulse data_valid with 0xFF -> 0xFF never appears on tx. Only 0x55 and 0x0F are sent.
5. Reset mid-frame: start 0x00, assert rst at cycle 35 of the frame -> tx=1 on the next edge, no done pulse. A later byte 0x81 is then sent correctly.
6. Loopback with the team's UART receiver at the defaults (CLKS_PER_BIT=5208), tx wired to rx: send 0x3C, then 0xC3 -> receiver shows data_out 0x3C then 0xC3, each with a one-cycle data_valid.
